// File: rtl/cp_pkg.sv
// Shared types for the coprocessor control sequencer.
// State encoding is fixed so software can decode the state output.
package cp_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_WEIGHTS = 3'd1,
    ST_DATA    = 3'd2,
    ST_RESULT  = 3'd3,
    ST_OUTPUT  = 3'd4
  } state_e;

endpackage

// File: rtl/cp_beat_counter.sv
// Saturating-free event counter that returns to zero on its last value.
// Used for stream beats, tiles and blocks.
module cp_beat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] last_val,
  output logic [CNT_W-1:0] count,
  output logic             is_last
);

  logic [CNT_W-1:0] count_q, count_d;

  assign is_last = (count_q == last_val);
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (inc)
      count_d = is_last ? '0 : count_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/cp_sequencer.sv
// Coprocessor control sequencer: weights -> (data -> result) x tiles,
// repeated per block, then output drain. Counts set at run time.
module cp_sequencer
  import cp_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned STATE_W = cp_pkg::STATE_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [CNT_W-1:0]   cfg_weight_beats,
  input  logic [CNT_W-1:0]   cfg_data_beats,
  input  logic [CNT_W-1:0]   cfg_tiles,
  input  logic [CNT_W-1:0]   cfg_blocks,
  input  logic [CNT_W-1:0]   cfg_out_beats,
  input  logic               wt_valid,
  output logic               wt_ready,
  input  logic               dat_valid,
  output logic               dat_ready,
  input  logic               res_valid,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   tile_idx,
  output logic [CNT_W-1:0]   block_idx,
  output logic               busy,
  output logic               done,
  output logic               abort,
  output logic               cfg_err
);

  state_e state_q;
  logic [CNT_W-1:0] w_q, d_q, t_q, b_q, o_q;
  logic done_q, abort_q, err_q, err_seen_q;

  logic in_i, in_w, in_d, in_r, in_o;
  logic cfg_bad, cnt_clr, res_hit;
  logic beat_inc, beat_last, tile_last, blk_last;
  logic [CNT_W-1:0] beat_lv, beat_cnt;

  assign in_i = (state_q == ST_IDLE);
  assign in_w = (state_q == ST_WEIGHTS);
  assign in_d = (state_q == ST_DATA);
  assign in_r = (state_q == ST_RESULT);
  assign in_o = (state_q == ST_OUTPUT);

  assign wt_ready  = in_w;
  assign dat_ready = in_d;
  assign out_valid = in_o;
  assign busy      = ~in_i;
  assign state     = STATE_W'(state_q);
  assign done      = done_q;
  assign abort     = abort_q;
  assign cfg_err   = err_q;

  assign cfg_bad = (cfg_weight_beats == '0) | (cfg_data_beats == '0)
                 | (cfg_tiles == '0) | (cfg_blocks == '0)
                 | (cfg_out_beats == '0);

  // Gating with enable makes abort win over a simultaneous last beat.
  assign cnt_clr  = ~enable | in_i;
  assign res_hit  = enable & in_r & res_valid;
  assign beat_inc = enable & ((in_w & wt_valid) | (in_d & dat_valid)
                            | (in_o & out_ready));

  always_comb begin
    beat_lv = '0;
    unique case (1'b1)
      in_w:    beat_lv = w_q - CNT_W'(1);
      in_d:    beat_lv = d_q - CNT_W'(1);
      in_o:    beat_lv = o_q - CNT_W'(1);
      default: beat_lv = '0;
    endcase
  end

  cp_beat_counter #(.CNT_W(CNT_W)) u_beat (
    .clock(clock), .reset(reset), .clr(cnt_clr), .inc(beat_inc),
    .last_val(beat_lv), .count(beat_cnt), .is_last(beat_last)
  );

  cp_beat_counter #(.CNT_W(CNT_W)) u_tile (
    .clock(clock), .reset(reset), .clr(cnt_clr), .inc(res_hit),
    .last_val(t_q - CNT_W'(1)), .count(tile_idx), .is_last(tile_last)
  );

  cp_beat_counter #(.CNT_W(CNT_W)) u_block (
    .clock(clock), .reset(reset), .clr(cnt_clr),
    .inc(res_hit & tile_last),
    .last_val(b_q - CNT_W'(1)), .count(block_idx), .is_last(blk_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      w_q        <= '0;
      d_q        <= '0;
      t_q        <= '0;
      b_q        <= '0;
      o_q        <= '0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      err_q      <= 1'b0;
      err_seen_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
      if (!enable) err_seen_q <= 1'b0;
      if (!in_i && !enable) begin
        state_q <= ST_IDLE;
        abort_q <= 1'b1;
      end else begin
        unique case (state_q)
          ST_IDLE: if (enable) begin
            if (cfg_bad) begin
              err_q      <= ~err_seen_q;
              err_seen_q <= 1'b1;
            end else begin
              w_q     <= cfg_weight_beats;
              d_q     <= cfg_data_beats;
              t_q     <= cfg_tiles;
              b_q     <= cfg_blocks;
              o_q     <= cfg_out_beats;
              state_q <= ST_WEIGHTS;
            end
          end
          ST_WEIGHTS:
            if (beat_inc && beat_last) state_q <= ST_DATA;
          ST_DATA:
            if (beat_inc && beat_last) state_q <= ST_RESULT;
          ST_RESULT: if (res_valid) begin
            if (!tile_last)     state_q <= ST_DATA;
            else if (!blk_last) state_q <= ST_WEIGHTS;
            else                state_q <= ST_OUTPUT;
          end
          ST_OUTPUT: if (beat_inc && beat_last) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cp_sequencer.sv
// Scoreboard bench for cp_sequencer: expected state/pulse events are
// queued by the stimulus and checked by an independent monitor.
module tb_cp_sequencer;

  localparam int S_I = 0, S_W = 1, S_D = 2, S_R = 3, S_O = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] cfg_weight_beats = 8'd2, cfg_data_beats = 8'd3;
  logic [7:0] cfg_tiles = 8'd2, cfg_blocks = 8'd1, cfg_out_beats = 8'd1;
  logic       wt_valid = 1'b1, dat_valid = 1'b1, res_valid = 1'b1;
  logic       out_ready = 1'b1;
  logic       wt_ready, dat_ready, out_valid, busy, done, abort, cfg_err;
  logic [2:0] state;
  logic [7:0] tile_idx, block_idx;

  cp_sequencer #(.CNT_W(8), .STATE_W(3)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .cfg_weight_beats(cfg_weight_beats), .cfg_data_beats(cfg_data_beats),
    .cfg_tiles(cfg_tiles), .cfg_blocks(cfg_blocks),
    .cfg_out_beats(cfg_out_beats),
    .wt_valid(wt_valid), .wt_ready(wt_ready),
    .dat_valid(dat_valid), .dat_ready(dat_ready),
    .res_valid(res_valid),
    .out_valid(out_valid), .out_ready(out_ready),
    .state(state), .tile_idx(tile_idx), .block_idx(block_idx),
    .busy(busy), .done(done), .abort(abort), .cfg_err(cfg_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int st; int tile; int blk; bit d; bit a; bit e;
  } ev_t;

  ev_t expq[$];
  int  n_tests = 0, n_fail = 0;
  bit  mon_en = 1'b0;
  int  prev_st = S_I;
  int  wt_hs = 0, wt_cyc = 0, busy_seen = 0;

  function automatic void ex(int st, int t, int b, bit d, bit a, bit e);
    ev_t v;
    v.st = st; v.tile = t; v.blk = b; v.d = d; v.a = a; v.e = e;
    expq.push_back(v);
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Monitor: any state change or pulse is one observable event.
  always @(negedge clock) begin
    if (mon_en) begin
      if (wt_valid && wt_ready) wt_hs++;
      if (int'(state) == S_W) wt_cyc++;
      if (busy) busy_seen++;
      if (int'(state) != prev_st || done || abort || cfg_err) begin
        n_tests++;
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: st=%0d tile=%0d blk=%0d d=%0b a=%0b e=%0b",
                   state, tile_idx, block_idx, done, abort, cfg_err);
        end else begin
          ev_t v;
          v = expq.pop_front();
          if (int'(state) != v.st || int'(tile_idx) != v.tile ||
              int'(block_idx) != v.blk || done !== v.d ||
              abort !== v.a || cfg_err !== v.e) begin
            n_fail++;
            $display("FAIL event: got st=%0d t=%0d b=%0d d=%0b a=%0b e=%0b, expected st=%0d t=%0d b=%0d d=%0b a=%0b e=%0b",
                     state, tile_idx, block_idx, done, abort, cfg_err,
                     v.st, v.tile, v.blk, v.d, v.a, v.e);
          end
        end
      end
      prev_st = int'(state);
    end
  end

  task automatic set_cfg(input int w, d, t, b, o);
    cfg_weight_beats = 8'(w); cfg_data_beats = 8'(d);
    cfg_tiles = 8'(t); cfg_blocks = 8'(b); cfg_out_beats = 8'(o);
  endtask

  task automatic clr_stats();
    wt_hs = 0; wt_cyc = 0; busy_seen = 0;
  endtask

  // Runs until done/abort; len = cycles from enable to the pulse.
  task automatic run(input string nm, input logic [7:0] pat,
                     input int drop_at, output int len);
    len = 0;
    enable = 1'b1;
    wt_valid = pat[0];
    for (int i = 1; i <= 200; i++) begin
      @(posedge clock); #1;
      if (done || abort) begin
        len = i;
        break;
      end
      wt_valid = (i < 8) ? pat[i] : 1'b1;
      if (i == drop_at) enable = 1'b0;
    end
    enable = 1'b0;
    wt_valid = 1'b1;
    if (len == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got no done/abort, expected one within 200 cycles", nm);
    end
    @(negedge clock); #1;
  endtask

  int len;

  initial begin
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    chk("rst_state", int'(state), S_I);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'({wt_ready, dat_ready, out_valid}), 0);
    chk("rst_pulses", int'({done, abort, cfg_err}), 0);
    chk("rst_idx", int'(tile_idx) + int'(block_idx), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    prev_st = S_I;
    mon_en = 1'b1;

    // 1: two tiles, one block, everything always ready.
    set_cfg(2, 3, 2, 1, 1);
    clr_stats();
    ex(S_W,0,0,0,0,0); ex(S_D,0,0,0,0,0); ex(S_R,0,0,0,0,0);
    ex(S_D,1,0,0,0,0); ex(S_R,1,0,0,0,0); ex(S_O,0,0,0,0,0);
    ex(S_I,0,0,1,0,0);
    run("s1", 8'hFF, -1, len);
    chk("s1_len", len, 12);
    chk("s1_wt_hs", wt_hs, 2);
    chk("s1_queue", expq.size(), 0);

    // 2: weight valid gap.
    clr_stats();
    ex(S_W,0,0,0,0,0); ex(S_D,0,0,0,0,0); ex(S_R,0,0,0,0,0);
    ex(S_D,1,0,0,0,0); ex(S_R,1,0,0,0,0); ex(S_O,0,0,0,0,0);
    ex(S_I,0,0,1,0,0);
    run("s2", 8'hFB, -1, len);
    chk("s2_len", len, 13);
    chk("s2_wt_cycles", wt_cyc, 3);
    chk("s2_wt_hs", wt_hs, 2);
    chk("s2_queue", expq.size(), 0);

    // 3: three blocks of one tile, two output beats.
    set_cfg(1, 1, 1, 3, 2);
    clr_stats();
    for (int b = 0; b < 3; b++) begin
      ex(S_W,0,b,0,0,0); ex(S_D,0,b,0,0,0); ex(S_R,0,b,0,0,0);
    end
    ex(S_O,0,0,0,0,0); ex(S_I,0,0,1,0,0);
    run("s3", 8'hFF, -1, len);
    chk("s3_len", len, 12);
    chk("s3_wt_hs", wt_hs, 3);
    chk("s3_queue", expq.size(), 0);

    // 4: zero tile count is refused; error re-arms on enable fall.
    set_cfg(2, 3, 0, 1, 1);
    clr_stats();
    ex(S_I,0,0,0,0,1);
    @(posedge clock); #1;
    enable = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    chk("s4_state", int'(state), S_I);
    chk("s4_busy_cycles", busy_seen, 0);
    chk("s4_queue1", expq.size(), 0);
    enable = 1'b0;
    ex(S_I,0,0,0,0,1);
    @(posedge clock); #1;
    enable = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    enable = 1'b0;
    @(negedge clock); #1;
    chk("s4_queue2", expq.size(), 0);

    // 5: enable drops on the final data beat of tile 1.
    set_cfg(1, 3, 2, 1, 1);
    ex(S_W,0,0,0,0,0); ex(S_D,0,0,0,0,0); ex(S_R,0,0,0,0,0);
    ex(S_D,1,0,0,0,0); ex(S_I,0,0,0,1,0);
    run("s5", 8'hFF, 8, len);
    chk("s5_len", len, 9);
    chk("s5_queue", expq.size(), 0);

    // 6: reset while draining output, then a clean restart.
    set_cfg(2, 3, 2, 1, 1);
    out_ready = 1'b0;
    ex(S_W,0,0,0,0,0); ex(S_D,0,0,0,0,0); ex(S_R,0,0,0,0,0);
    ex(S_D,1,0,0,0,0); ex(S_R,1,0,0,0,0); ex(S_O,0,0,0,0,0);
    ex(S_I,0,0,0,0,0);
    enable = 1'b1;
    len = 0;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clock); #1;
      if (int'(state) == S_O) begin
        len = i;
        break;
      end
    end
    chk("s6_reach_out", len, 11);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("s6_state", int'(state), S_I);
    chk("s6_out_valid", int'(out_valid), 0);
    chk("s6_no_pulse", int'({done, abort}), 0);
    out_ready = 1'b1;
    ex(S_W,0,0,0,0,0); ex(S_D,0,0,0,0,0); ex(S_R,0,0,0,0,0);
    ex(S_D,1,0,0,0,0); ex(S_R,1,0,0,0,0); ex(S_O,0,0,0,0,0);
    ex(S_I,0,0,1,0,0);
    run("s6", 8'hFF, -1, len);
    chk("s6_len", len, 12);
    repeat (3) @(negedge clock);
    chk("s6_queue", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
